// File: rtl/msft_dv_debug_bkdr_pkg.sv
// rtl/msft_dv_debug_bkdr_pkg.sv - shared types for the debug backdoor APB arbiter
//
// Purpose: state encoding and captured request/response records used by
//          msft_dv_debug_bkdr_arb. Record field widths match the arbiter's
//          default ADDR_WIDTH/DATA_WIDTH; instances with wider buses need
//          these localparams raised to match.
package msft_dv_debug_bkdr_pkg;

    localparam int unsigned BKDR_ADDR_W = 32;
    localparam int unsigned BKDR_DATA_W = 48;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } bkdr_state_e;

    typedef struct packed {
        logic [BKDR_ADDR_W-1:0] addr;
        logic [BKDR_DATA_W-1:0] wdata;
        logic                   write;
    } apb_req_t;

    typedef struct packed {
        logic [BKDR_DATA_W-1:0] rdata;
        logic                   err;
    } apb_rsp_t;

endpackage

// File: rtl/msft_dv_debug_bkdr_arb.sv
// rtl/msft_dv_debug_bkdr_arb.sv - two-requester round-robin APB arbiter for the debug backdoor
//
// Purpose: lets the JTAG debug bridge (m0) and the host loader (m1) share one
//          downstream APB slave. Each transfer is arbitrated in IDLE, captured,
//          replayed downstream as SETUP/ACCESS, and answered with a one-cycle
//          pready pulse to the winner only. A per-transfer timeout forces an
//          error response when the slave never asserts pready.
//
// Ports:
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   psel/penable/paddr/pwdata/pwrite_m{0,1}_i   requester APB inputs
//   prdata/pready/psuberr_m{0,1}_o              requester responses
//   psel_o/penable_o/paddr_o/pwdata_o/pwrite_o  downstream APB request
//   prdata_i/pready_i/psuberr_i                 downstream APB response
//   grant_o                       owner of current or last transfer (0=m0, 1=m1)
//   busy_o                        high whenever the FSM is not IDLE
module msft_dv_debug_bkdr_arb
    import msft_dv_debug_bkdr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = BKDR_ADDR_W,
    parameter int unsigned DATA_WIDTH     = BKDR_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,

    input  logic                  psel_m0_i,
    input  logic                  penable_m0_i,
    input  logic [ADDR_WIDTH-1:0] paddr_m0_i,
    input  logic [DATA_WIDTH-1:0] pwdata_m0_i,
    input  logic                  pwrite_m0_i,
    output logic [DATA_WIDTH-1:0] prdata_m0_o,
    output logic                  pready_m0_o,
    output logic                  psuberr_m0_o,

    input  logic                  psel_m1_i,
    input  logic                  penable_m1_i,
    input  logic [ADDR_WIDTH-1:0] paddr_m1_i,
    input  logic [DATA_WIDTH-1:0] pwdata_m1_i,
    input  logic                  pwrite_m1_i,
    output logic [DATA_WIDTH-1:0] prdata_m1_o,
    output logic                  pready_m1_o,
    output logic                  psuberr_m1_o,

    output logic                  psel_o,
    output logic                  penable_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  pwrite_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  psuberr_i,

    output logic                  grant_o,
    output logic                  busy_o
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

    bkdr_state_e      state_q, state_d;
    apb_req_t         req_q, req_d;
    apb_rsp_t         rsp_q, rsp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_q, grant_d;
    logic             win_m1;
    logic             timeout_hit;

    // penable from requesters is not needed: a request is psel alone.
    logic unused_penable;
    assign unused_penable = penable_m0_i ^ penable_m1_i;

    // Under contention the requester not named by last_grant wins.
    always_comb begin
        win_m1 = psel_m1_i;
        if (psel_m0_i && psel_m1_i) begin
            win_m1 = ~last_grant_q;
        end
    end

    // cnt_q equals the number of ACCESS cycles already spent waiting, so the
    // final counted cycle is reached at TIMEOUT_CYCLES-1.
    assign timeout_hit = TO_EN && (cnt_q == CNT_W'(TO_LAST));

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        rsp_d        = rsp_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (psel_m0_i || psel_m1_i) begin
                    grant_d      = win_m1;
                    last_grant_d = win_m1;
                    req_d.addr   = win_m1 ? BKDR_ADDR_W'(paddr_m1_i)  : BKDR_ADDR_W'(paddr_m0_i);
                    req_d.wdata  = win_m1 ? BKDR_DATA_W'(pwdata_m1_i) : BKDR_DATA_W'(pwdata_m0_i);
                    req_d.write  = win_m1 ? pwrite_m1_i : pwrite_m0_i;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A real pready in the last counted cycle beats the timeout.
                if (pready_i) begin
                    rsp_d.rdata = req_q.write ? '0 : BKDR_DATA_W'(prdata_i);
                    rsp_d.err   = psuberr_i;
                    state_d     = RESP;
                end else if (timeout_hit) begin
                    rsp_d.rdata = '0;
                    rsp_d.err   = 1'b1;
                    state_d     = RESP;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // grant_o resets to m0 while last_grant resets to m1, so the two are kept
    // in separate flops even though they agree after the first transfer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            req_q        <= '0;
            rsp_q        <= '0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            rsp_q        <= rsp_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
        end
    end

    // All outputs decode flops only, so they move on clock edges or reset.
    assign psel_o    = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o = (state_q == ACCESS);
    assign paddr_o   = ADDR_WIDTH'(req_q.addr);
    assign pwdata_o  = DATA_WIDTH'(req_q.wdata);
    assign pwrite_o  = req_q.write;

    assign pready_m0_o  = (state_q == RESP) && !grant_q;
    assign pready_m1_o  = (state_q == RESP) &&  grant_q;
    assign prdata_m0_o  = pready_m0_o ? DATA_WIDTH'(rsp_q.rdata) : '0;
    assign prdata_m1_o  = pready_m1_o ? DATA_WIDTH'(rsp_q.rdata) : '0;
    assign psuberr_m0_o = pready_m0_o && rsp_q.err;
    assign psuberr_m1_o = pready_m1_o && rsp_q.err;

    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_msft_dv_debug_bkdr_arb.sv
// tb/tb_msft_dv_debug_bkdr_arb.sv - directed self-checking bench for msft_dv_debug_bkdr_arb
module tb_msft_dv_debug_bkdr_arb;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        psel_m0_i, penable_m0_i, pwrite_m0_i;
    logic [31:0] paddr_m0_i;
    logic [47:0] pwdata_m0_i, prdata_m0_o;
    logic        pready_m0_o, psuberr_m0_o;
    logic        psel_m1_i, penable_m1_i, pwrite_m1_i;
    logic [31:0] paddr_m1_i;
    logic [47:0] pwdata_m1_i, prdata_m1_o;
    logic        pready_m1_o, psuberr_m1_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [31:0] paddr_o;
    logic [47:0] pwdata_o, prdata_i;
    logic        pready_i, psuberr_i;
    logic        grant_o, busy_o;

    int n_cmp = 0;
    int n_err = 0;

    msft_dv_debug_bkdr_arb #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (48),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .psel_m0_i    (psel_m0_i),
        .penable_m0_i (penable_m0_i),
        .paddr_m0_i   (paddr_m0_i),
        .pwdata_m0_i  (pwdata_m0_i),
        .pwrite_m0_i  (pwrite_m0_i),
        .prdata_m0_o  (prdata_m0_o),
        .pready_m0_o  (pready_m0_o),
        .psuberr_m0_o (psuberr_m0_o),
        .psel_m1_i    (psel_m1_i),
        .penable_m1_i (penable_m1_i),
        .paddr_m1_i   (paddr_m1_i),
        .pwdata_m1_i  (pwdata_m1_i),
        .pwrite_m1_i  (pwrite_m1_i),
        .prdata_m1_o  (prdata_m1_o),
        .pready_m1_o  (pready_m1_o),
        .psuberr_m1_o (psuberr_m1_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .paddr_o      (paddr_o),
        .pwdata_o     (pwdata_o),
        .pwrite_o     (pwrite_o),
        .prdata_i     (prdata_i),
        .pready_i     (pready_i),
        .psuberr_i    (psuberr_i),
        .grant_o      (grant_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic req(input bit m, input logic [31:0] a, input logic [47:0] wd, input bit wr);
        if (m) begin
            psel_m1_i = 1'b1; penable_m1_i = 1'b0; paddr_m1_i = a; pwdata_m1_i = wd; pwrite_m1_i = wr;
        end else begin
            psel_m0_i = 1'b1; penable_m0_i = 1'b0; paddr_m0_i = a; pwdata_m0_i = wd; pwrite_m0_i = wr;
        end
    endtask

    task automatic do_reset();
        psel_m0_i = 1'b0; psel_m1_i = 1'b0; penable_m0_i = 1'b0; penable_m1_i = 1'b0;
        pready_i = 1'b0;
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        tick();
    endtask

    // Called in IDLE with requests already driven. waits = extra ACCESS cycles
    // before pready_i; hang holds pready_i low for the whole timeout window.
    task automatic serve(input bit g, input logic [31:0] a, input logic [47:0] wd, input bit wr,
                         input int waits, input bit hang, input logic [47:0] rd, input bit err);
        logic [47:0] exp_rd;
        logic        exp_err;
        int          last;
        exp_rd  = hang ? 48'h0 : (wr ? 48'h0 : rd);
        exp_err = hang ? 1'b1 : err;
        last    = hang ? TO - 1 : waits;
        prdata_i  = rd;
        psuberr_i = err;
        pready_i  = 1'b0;
        tick();
        chk("setup_psel",    psel_o, 1);
        chk("setup_penable", penable_o, 0);
        chk("setup_paddr",   paddr_o, a);
        chk("setup_pwdata",  pwdata_o, wd);
        chk("setup_pwrite",  pwrite_o, wr);
        chk("setup_grant",   grant_o, g);
        chk("setup_busy",    busy_o, 1);
        if (g) penable_m1_i = 1'b1; else penable_m0_i = 1'b1;
        tick();
        for (int i = 0; i <= last; i++) begin
            chk("acc_psel",    psel_o, 1);
            chk("acc_penable", penable_o, 1);
            chk("acc_paddr",   paddr_o, a);
            chk("acc_pwdata",  pwdata_o, wd);
            chk("acc_pwrite",  pwrite_o, wr);
            chk("acc_rdy_m0",  pready_m0_o, 0);
            chk("acc_rdy_m1",  pready_m1_o, 0);
            pready_i = (i == last) && !hang;
            tick();
        end
        pready_i = 1'b0;
        chk("resp_psel",      psel_o, 0);
        chk("resp_penable",   penable_o, 0);
        chk("resp_grant",     grant_o, g);
        chk("resp_rdy_win",   g ? pready_m1_o : pready_m0_o, 1);
        chk("resp_rdy_lose",  g ? pready_m0_o : pready_m1_o, 0);
        chk("resp_rdata_win", g ? prdata_m1_o : prdata_m0_o, exp_rd);
        chk("resp_rdata_lose",g ? prdata_m0_o : prdata_m1_o, 0);
        chk("resp_err_win",   g ? psuberr_m1_o : psuberr_m0_o, exp_err);
        chk("resp_err_lose",  g ? psuberr_m0_o : psuberr_m1_o, 0);
        if (g) begin psel_m1_i = 1'b0; penable_m1_i = 1'b0; end
        else   begin psel_m0_i = 1'b0; penable_m0_i = 1'b0; end
        tick();
        chk("idle_busy",   busy_o, 0);
        chk("idle_rdy_m0", pready_m0_o, 0);
        chk("idle_rdy_m1", pready_m1_o, 0);
        chk("idle_rdata",  g ? prdata_m1_o : prdata_m0_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rstn_i = 1'b0;
        psel_m0_i = 0; penable_m0_i = 0; paddr_m0_i = 0; pwdata_m0_i = 0; pwrite_m0_i = 0;
        psel_m1_i = 0; penable_m1_i = 0; paddr_m1_i = 0; pwdata_m1_i = 0; pwrite_m1_i = 0;
        prdata_i = 0; pready_i = 0; psuberr_i = 0;
        repeat (3) tick();
        chk("rst_psel",    psel_o, 0);
        chk("rst_penable", penable_o, 0);
        chk("rst_paddr",   paddr_o, 0);
        chk("rst_rdy_m0",  pready_m0_o, 0);
        chk("rst_rdy_m1",  pready_m1_o, 0);
        chk("rst_grant",   grant_o, 0);
        chk("rst_busy",    busy_o, 0);
        rstn_i = 1'b1;
        tick();

        // single m0 read, no wait states
        req(0, 32'h0043_0010, 48'h0, 0);
        serve(0, 32'h0043_0010, 48'h0, 0, 0, 0, 48'h0000_c001_c0de, 0);

        // simultaneous requests after reset: m0 first, then m1
        do_reset();
        req(0, 32'h0000_0100, 48'h0000_0000_00a0, 0);
        req(1, 32'h0000_0200, 48'h0000_0000_00b1, 1);
        serve(0, 32'h0000_0100, 48'h0000_0000_00a0, 0, 0, 0, 48'h0000_0000_1111, 0);
        serve(1, 32'h0000_0200, 48'h0000_0000_00b1, 1, 0, 0, 48'h0000_0000_2222, 0);
        for (int k = 0; k < 4; k++) begin
            req(0, 32'h0000_0100, 48'h0000_0000_00a0, 0);
            req(1, 32'h0000_0200, 48'h0000_0000_00b1, 1);
            if (k % 2 == 0)
                serve(0, 32'h0000_0100, 48'h0000_0000_00a0, 0, 0, 0, 48'h0000_0000_3333, 0);
            else
                serve(1, 32'h0000_0200, 48'h0000_0000_00b1, 1, 0, 0, 48'h0000_0000_4444, 0);
        end
        psel_m0_i = 1'b0;
        psel_m1_i = 1'b0;

        // m1 write with 3 wait states
        req(1, 32'h0010_0000, 48'h1234_5678_9abc, 1);
        serve(1, 32'h0010_0000, 48'h1234_5678_9abc, 1, 3, 0, 48'hffff_ffff_ffff, 0);

        // timeout after 8 ACCESS cycles, then pready_i in cycle 8 completes normally
        req(0, 32'h0020_0000, 48'h0, 0);
        serve(0, 32'h0020_0000, 48'h0, 0, 0, 1, 48'h0000_0000_ffff, 0);
        req(0, 32'h0020_0004, 48'h0, 0);
        serve(0, 32'h0020_0004, 48'h0, 0, TO - 1, 0, 48'h0000_5a5a_a5a5, 0);

        // downstream error on an unmapped read goes to the winner only
        req(1, 32'hdead_0000, 48'h0, 0);
        serve(1, 32'hdead_0000, 48'h0, 0, 0, 0, 48'h0000_0000_0bad, 1);

        // asynchronous reset during ACCESS
        req(0, 32'h0000_0300, 48'h0, 0);
        pready_i = 1'b0;
        tick();
        tick();
        chk("pre_rst_penable", penable_o, 1);
        #3;
        rstn_i = 1'b0;
        #1;
        chk("arst_psel",    psel_o, 0);
        chk("arst_penable", penable_o, 0);
        chk("arst_rdy_m0",  pready_m0_o, 0);
        chk("arst_rdy_m1",  pready_m1_o, 0);
        chk("arst_busy",    busy_o, 0);
        chk("arst_grant",   grant_o, 0);
        psel_m0_i = 1'b0;
        penable_m0_i = 1'b0;
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        req(1, 32'h0000_0400, 48'h0, 0);
        serve(1, 32'h0000_0400, 48'h0, 0, 1, 0, 48'h0000_beef_0001, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
